// File: rtl/prim_gate_exerciser_pkg.sv
// Shared types for the gate-primitive exerciser.
// Operation codes and sweep FSM states.
package prim_exerciser_pkg;

    typedef enum logic [2:0] {
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_XNOR,
        OP_NAND,
        OP_NOR,
        OP_BUF,
        OP_NOT
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

endpackage

// File: rtl/prim_gate_exerciser_if.sv
// Bundle between the exerciser and the unit-test top level.
// The slave side is the exerciser; the master drives start/op/dut_y.
interface prim_gate_exerciser_if #(
    parameter int N_IN = 3
);
    import prim_exerciser_pkg::*;

    logic            start;
    op_e             op;
    logic [N_IN-1:0] stim;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        output start, op, dut_y,
        input  stim, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, op, dut_y,
        output stim, busy, done, pass, err_count, fail_vec
    );

endinterface

// File: rtl/prim_gate_exerciser_golden.sv
// Golden model for single-output gate primitives.
// Purely combinational; reusable as a standalone reference.
module prim_golden
    import prim_exerciser_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  op_e             op,
    input  logic [N_IN-1:0] a,
    output logic            y
);

    always_comb begin
        y = 1'b0;
        unique case (op)
            OP_AND:  y = &a;
            OP_OR:   y = |a;
            OP_XOR:  y = ^a;
            OP_XNOR: y = ~^a;
            OP_NAND: y = ~&a;
            OP_NOR:  y = ~|a;
            OP_BUF:  y = a[0];
            OP_NOT:  y = ~a[0];
        endcase
    end

endmodule

// File: rtl/prim_gate_exerciser.sv
// Exhaustive clocked sweep of a gate primitive against a golden model.
// Reports pass/fail, mismatch count and the first failing vector.
module prim_gate_exerciser
    import prim_exerciser_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prim_gate_exerciser_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [3:0]      settle_q, settle_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;
    logic            pass_q, pass_d;
    logic            gold;
    logic            miss;

    prim_golden #(.N_IN(N_IN)) u_golden (
        .op (op_q),
        .a  (stim_q),
        .y  (gold)
    );

    // X/Z on the primitive output must count as a failure
    assign miss = (bus.dut_y !== gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_AND;
            vec_q    <= '0;
            stim_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            vec_q    <= vec_d;
            stim_q   <= stim_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        vec_d    = vec_q;
        stim_d   = stim_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        unique case (state_q)
            S_IDLE: begin
                stim_d = '0;
                if (bus.start) begin
                    op_d     = bus.op;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fail_d   = '0;
                    pass_d   = 1'b0;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (miss) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) fail_d = stim_q;
                end
                if (vec_q == '1) begin
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    stim_d  = vec_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                stim_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.stim      = stim_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_prim_gate_exerciser.sv
// Randomised self-checking bench for prim_gate_exerciser.
// Two instances: N_IN=3/SETTLE=1 and N_IN=1/SETTLE=3.
module tb_prim_gate_exerciser;
    import prim_exerciser_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    op_e  op_v = OP_AND;
    logic [255:0] tt_a = '0;
    logic [255:0] tt_b = '0;
    int   cur = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    prim_gate_exerciser_if #(.N_IN(3)) b_a ();
    prim_gate_exerciser_if #(.N_IN(1)) b_b ();

    assign b_a.start = start_a;
    assign b_a.op    = op_v;
    assign b_a.dut_y = tt_a[b_a.stim];
    assign b_b.start = start_b;
    assign b_b.op    = op_v;
    assign b_b.dut_y = tt_b[b_b.stim];

    prim_gate_exerciser #(.N_IN(3), .SETTLE(1)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_a)
    );

    prim_gate_exerciser #(.N_IN(1), .SETTLE(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_b)
    );

    logic [31:0] stim_m, err_m, fail_m;
    logic        busy_m, done_m, pass_m;

    always_comb begin
        stim_m = (cur != 0) ? 32'(b_b.stim)      : 32'(b_a.stim);
        err_m  = (cur != 0) ? 32'(b_b.err_count) : 32'(b_a.err_count);
        fail_m = (cur != 0) ? 32'(b_b.fail_vec)  : 32'(b_a.fail_vec);
        busy_m = (cur != 0) ? b_b.busy : b_a.busy;
        done_m = (cur != 0) ? b_b.done : b_a.done;
        pass_m = (cur != 0) ? b_b.pass : b_a.pass;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_gate(input op_e o, input int k, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (k >> i) & 1;
        case (o)
            OP_AND:  return ones == n;
            OP_OR:   return ones > 0;
            OP_XOR:  return (ones % 2) == 1;
            OP_XNOR: return (ones % 2) == 0;
            OP_NAND: return ones != n;
            OP_NOR:  return ones == 0;
            OP_BUF:  return (k & 1) == 1;
            default: return (k & 1) == 0;
        endcase
    endfunction

    function automatic logic [255:0] tt_gate(input op_e o, input int n);
        logic [255:0] t;
        t = '0;
        for (int k = 0; k < (1 << n); k++) t[k] = ref_gate(o, k, n);
        return t;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy_m), 0);
        chk({tag, "_done"}, 32'(done_m), 0);
        chk({tag, "_pass"}, 32'(pass_m), 0);
        chk({tag, "_err"},  err_m, 0);
        chk({tag, "_stim"}, stim_m, 0);
        chk({tag, "_fail"}, fail_m, 0);
    endtask

    // mode 0: plain, 1: start/op disturbed mid-sweep, 2: reset mid-sweep
    task automatic run_sweep(input int sel, input op_e o,
                             input logic [255:0] tt, input int mode);
        int n, s, nv, span, exp_err, exp_fail, c, dcyc, ndone;
        n = (sel != 0) ? 1 : 3;
        s = (sel != 0) ? 3 : 1;
        nv = 1 << n;
        span = nv * (s + 1);
        exp_err = 0;
        exp_fail = 0;
        for (int k = 0; k < nv; k++) begin
            if (tt[k] != ref_gate(o, k, n)) begin
                if (exp_err == 0) exp_fail = k;
                exp_err++;
            end
        end
        @(negedge clk);
        cur = sel;
        if (sel != 0) tt_b = tt; else tt_a = tt;
        op_v = o;
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("acc_busy", 32'(busy_m), 1);
        chk("acc_stim", stim_m, 0);
        c = 0;
        ndone = 0;
        dcyc = -1;
        while (c < span + 3) begin
            if (done_m) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end else if (c < span) begin
                chk("stim_walk", stim_m, 32'(c / (s + 1)));
            end
            if (c == span + 1) chk("busy_fall", 32'(busy_m), 0);
            if (mode == 1 && c == 5) begin
                op_v = op_e'(o ^ 3'd5);
                if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
            end
            if (mode == 1 && c == 6) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (mode == 2 && c == 6) begin
                rst_n = 1'b0;
                #1;
                chk_reset("midrst");
                @(negedge clk);
                chk("midrst_nodone", 32'(done_m), 0);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            c++;
        end
        chk("done_cycle", 32'(dcyc), 32'(span));
        chk("done_count", 32'(ndone), 1);
        chk("err_count", err_m, 32'(exp_err));
        chk("fail_vec", fail_m, 32'(exp_fail));
        chk("pass", 32'(pass_m), 32'(exp_err == 0));
    endtask

    initial begin
        int sel, nn, pick;
        op_e o;
        logic [255:0] t;
        repeat (3) @(negedge clk);
        cur = 0;
        chk_reset("rst_a");
        cur = 1;
        chk_reset("rst_b");
        rst_n = 1'b1;

        run_sweep(0, OP_AND, tt_gate(OP_AND, 3), 0);
        run_sweep(0, OP_OR, '0, 0);
        run_sweep(0, OP_XNOR, tt_gate(OP_XOR, 3), 0);
        run_sweep(1, OP_NOT, tt_gate(OP_NOT, 1), 0);
        run_sweep(1, OP_BUF, tt_gate(OP_NOT, 1), 0);
        run_sweep(0, OP_XOR, tt_gate(OP_XOR, 3), 1);
        run_sweep(0, OP_NOR, tt_gate(OP_AND, 3), 1);
        run_sweep(0, OP_NAND, tt_gate(OP_NAND, 3), 2);
        run_sweep(0, OP_NAND, tt_gate(OP_NAND, 3), 0);

        for (int it = 0; it < 24; it++) begin
            sel  = int'($urandom_range(0, 1));
            nn   = (sel != 0) ? 1 : 3;
            o    = op_e'($urandom_range(0, 7));
            pick = int'($urandom_range(0, 2));
            if (pick == 0) t = tt_gate(o, nn);
            else if (pick == 1) t = tt_gate(op_e'($urandom_range(0, 7)), nn);
            else t = 256'($urandom);
            run_sweep(sel, o, t, (it % 5 == 4) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prim_gate_exerciser.md
# prim_gate_exerciser

Self-checking stimulus driver and response checker for single-output gate primitives (`and`, `or`, `xor`, `xnor`, `nand`, `nor`, `buf`, `not`). It drives every input combination into a combinational primitive-under-test, samples the output after a configurable settle time, and compares it against a built-in golden model. It reports a pass/fail summary, a mismatch count and the first failing vector. It sits beside a primitive instance in unit-test top levels and replaces hand-written immediate assertions with an exhaustive, clocked sweep.

## Interface
Parameters:
- `N_IN`, 3: number of gate inputs driven; 1..8.
- `SETTLE`, 1: cycles between a stimulus update and its sample; 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `op`  in  3  primitive under test (`op_e`); sampled only when `start` is accepted.
- `stim`  out  N_IN  registered stimulus to the primitive inputs.
- `dut_y`  in  1  primitive output.
- `busy`  out  1  high from sweep accept until DONE is exited.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  result of the last completed sweep.
- `err_count`  out  N_IN+1  mismatch count of the current or last sweep.
- `fail_vec`  out  N_IN  stimulus of the first mismatch; valid when `err_count != 0`.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE: `stim` = 0, `busy` = 0. When `start` = 1, latch `op` into `op_q`, set `vec` = 0, clear `err_count`, `fail_vec` and `pass`, then go to DRIVE.
- DRIVE: `stim` = `vec`. Hold for SETTLE cycles, counted by `settle_cnt`, then go to CHECK.
- CHECK: compare `dut_y` against `golden(op_q, stim)` on the exiting edge.
  - On a mismatch, increment `err_count`.
  - If `err_count` was 0 before the increment, capture `fail_vec` = `stim`.
  - If `vec` = 2^N_IN−1, go to DONE. Otherwise `vec` += 1 and return to DRIVE.
- DONE: `done` = 1 for exactly one cycle, `pass` = (`err_count` == 0), then go to IDLE. `pass`, `err_count` and `fail_vec` hold until the next accepted `start`.
- Golden model:
  - `and`/`or`/`xor`: reduction of `stim`.
  - `nand`/`nor`/`xnor`: the inverted reduction.
  - `buf`: `stim[0]`.
  - `not`: `~stim[0]`.
  - For N_IN = 1, every reduction equals `stim[0]` or its inverse.
- `op` encodings 8..: none exist, since `op` is 3 bits and all 8 codes are defined.
- `err_count` width N_IN+1 holds 2^N_IN without overflow, so no saturation logic is needed.
- A `dut_y` of X/Z in simulation counts as a mismatch, because the comparison is `!==` against a 0/1 value.

## Timing
- Reset values: `stim` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `fail_vec` = 0, state = IDLE.
- Start accepted at edge e0 → `stim` = 0 and `busy` = 1 visible after e0.
- Each vector occupies SETTLE+1 cycles. The sample for vector k is taken at edge e0 + (k+1)(SETTLE+1).
- `done` is high in the cycle after edge e0 + 2^N_IN·(SETTLE+1). `busy` falls on the same edge that `done` falls.
- `start` while `busy` = 1: ignored, with no restart and no effect on `op_q`.
- `start` in the DONE cycle: ignored. A new sweep needs `start` in IDLE.
- Reset asserted mid-sweep: all outputs return to reset values immediately. There is no partial result, and `done` does not pulse.
- `op` changes during a sweep have no effect.

## Structure
- Package `prim_exerciser_pkg`:
  - `typedef enum logic [2:0] op_e {OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_BUF, OP_NOT}`.
  - `typedef enum logic [1:0] state_e`.
- Sub-module `prim_golden`: combinational, parameter `N_IN`, inputs `op`/`a`, output `y`. It is also reusable as a standalone reference in other primitive tests.

## Test plan
- N_IN = 3, SETTLE = 1, `op` = OP_AND, correct `and` gate → `done` 16 cycles after the start edge, `pass` = 1, `err_count` = 0, `stim` walks 0..7.
- `op` = OP_OR, DUT stuck at 0 → `err_count` = 7, `fail_vec` = 3'b001, `pass` = 0.
- `op` = OP_XNOR, DUT wired as `xor` → `err_count` = 8, `fail_vec` = 3'b000.
- N_IN = 1, SETTLE = 3, `op` = OP_NOT, correct `not` → `done` 8 cycles after start, `pass` = 1. Repeat with `op` = OP_BUF on the same `not` → `err_count` = 2.
- `start` pulsed at cycle 5 of a running sweep with `op` changed → ignored: same results as an undisturbed sweep, single `done`.
- `rst_n` low at cycle 6 of a sweep → all outputs 0 asynchronously. A fresh start after release produces a full correct sweep.
